// File: rtl/ifft8_stream.sv
// ----------------------------------------------------------------------------
// ifft8_stream
//   Streaming 8-point inverse DFT.  A frame of eight frequency bins X[0..7] is
//   loaded one bin per handshake, then each time sample
//       x[n] = (1/8) * sum_k X[k] * e^(+j*2*pi*k*n/8)
//   is computed by accumulating one twiddled term per cycle (8 cycles per n)
//   and presented on a valid/ready output until it is accepted.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   bin presented          in_ready  block accepts bins (LOAD)
//     in_re/im   bin, signed W bits
//     out_valid  sample presented       out_ready consumer accepts sample
//     out_re/im  sample, signed W bits  out_last  high with sample n=7
//     busy       high whenever the block is not in LOAD
// ----------------------------------------------------------------------------
module ifft8_stream #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                busy
);

    localparam int AW = W + 8;   // accumulator width
    localparam int PW = W + 16;  // width of the 0.7071 product

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [2:0]             n_q, n_d;
    logic signed [AW-1:0]   acc_re_q, acc_re_d;
    logic signed [AW-1:0]   acc_im_q, acc_im_d;
    logic signed [W-1:0]    out_re_q, out_re_d;
    logic signed [W-1:0]    out_im_q, out_im_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [W-1:0]    bin_re_q [8];
    logic signed [W-1:0]    bin_im_q [8];
    logic                   bin_we;

    logic [2:0]             angle;
    logic signed [W-1:0]    xr, xi;
    logic signed [AW-1:0]   ext_re, ext_im;
    logic signed [AW-1:0]   cp_re, cn_re, cp_im, cn_im;
    logic signed [AW-1:0]   term_re, term_im;
    logic signed [AW-1:0]   sum_re, sum_im;

    // x * (+/-23170) >>> 15, i.e. x * (+/-0.7071) rounded toward -inf.  The
    // sign is applied to the product before the shift, so the negative
    // coefficient floors independently of the positive one.
    function automatic logic signed [AW-1:0] mul_c(input logic signed [W-1:0] x,
                                                   input logic neg);
        logic signed [PW-1:0] p;
        p = $signed(PW'(x)) * $signed(PW'(23170));
        if (neg) begin
            p = -p;
        end
        return AW'(p >>> 15);
    endfunction

    // ------------------------------------------------------------------
    // Bin buffer: one write port, addressed by the load index.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_bin
        always_ff @(posedge clk) begin
            if (bin_we && (k_q == 3'(gi))) begin
                bin_re_q[gi] <= in_re;
                bin_im_q[gi] <= in_im;
            end
        end
    end

    // ------------------------------------------------------------------
    // Twiddle term for bin k at sample n.  Angle index a = k*n mod 8
    // selects (cos, sin) from {0, +/-1, +/-0.7071}; exact coefficients are
    // handled by routing/negation only.
    // ------------------------------------------------------------------
    assign angle  = 3'(k_q * n_q);
    assign xr     = bin_re_q[k_q];
    assign xi     = bin_im_q[k_q];
    assign ext_re = AW'(xr);
    assign ext_im = AW'(xi);
    assign cp_re  = mul_c(xr, 1'b0);
    assign cn_re  = mul_c(xr, 1'b1);
    assign cp_im  = mul_c(xi, 1'b0);
    assign cn_im  = mul_c(xi, 1'b1);

    always_comb begin
        term_re = '0;
        term_im = '0;
        case (angle)
            3'd0: begin term_re = ext_re;        term_im = ext_im;        end
            3'd1: begin term_re = cp_re - cp_im; term_im = cp_re + cp_im; end
            3'd2: begin term_re = -ext_im;       term_im = ext_re;        end
            3'd3: begin term_re = cn_re - cp_im; term_im = cp_re + cn_im; end
            3'd4: begin term_re = -ext_re;       term_im = -ext_im;       end
            3'd5: begin term_re = cn_re - cn_im; term_im = cn_re + cn_im; end
            3'd6: begin term_re = ext_im;        term_im = -ext_re;       end
            default: begin term_re = cp_re - cn_im; term_im = cn_re + cp_im; end
        endcase
    end

    assign sum_re = acc_re_q + term_re;
    assign sum_im = acc_im_q + term_im;

    // ------------------------------------------------------------------
    // Control: next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_valid_d = out_valid_q;
        bin_we      = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    bin_we = !rst;
                    k_d    = k_q + 3'd1;   // wraps to 0 after bin 7
                    if (k_q == 3'd7) begin
                        state_d = CALC;
                        n_d     = 3'd0;
                    end
                end
            end
            CALC: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    // Final term: scale by 1/8 and present.  The accumulator
                    // is cleared here so the next n starts from zero.
                    out_re_d    = W'(sum_re >>> 3);
                    out_im_d    = W'(sum_im >>> 3);
                    out_valid_d = 1'b1;
                    acc_re_d    = '0;
                    acc_im_d    = '0;
                    state_d     = OUT;
                end else begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    k_d         = 3'd0;
                    if (n_q == 3'd7) begin
                        n_d     = 3'd0;
                        state_d = LOAD;
                    end else begin
                        n_d     = n_q + 3'd1;
                        state_d = CALC;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                k_d     = 3'd0;
                n_d     = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            k_q         <= '0;
            n_q         <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_last  = out_valid_q && (n_q == 3'd7);

endmodule

// File: tb/tb_ifft8_stream.sv
// ----------------------------------------------------------------------------
// tb_ifft8_stream
//   Randomized stimulus for ifft8_stream checked against a behavioural
//   inverse-DFT model (cos/sin table, per-product floor shift, /8 floor).
//   Directed frames: DC, impulse spectrum, single bin, backpressure, reset
//   mid-frame, back-to-back throughput; then random frames with random
//   output backpressure and input gaps.
// ----------------------------------------------------------------------------
module tb_ifft8_stream;

    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_last;
    logic                busy;

    ifft8_stream #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef int frame_t [8];
    typedef struct {
        int re;
        int im;
        bit last;
    } samp_t;

    samp_t exp_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    or_mode = 0;        // 0: out_ready low, 1: high, 2: random
    int    first_acc_cyc = 0;
    int    got_idx = 0;
    int    got_re [8];
    int    got_im [8];
    bit    got_last [8];

    // cos/sin of m*45 degrees in Q15; +/-1 is 32768 so the same
    // multiply-and-floor-shift gives the exact value.
    int cos_t [8] = '{32768, 23170, 0, -23170, -32768, -23170, 0, 23170};
    int sin_t [8] = '{0, 23170, 32768, 23170, 0, -23170, -32768, -23170};

    function automatic void chk(string name, bit ok, longint act, longint req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic void chk_eq(string name, longint act, longint req);
        chk(name, act == req, act, req);
    endfunction

    function automatic longint qmul(int x, int c);
        longint p;
        p = longint'(x) * longint'(c);
        return p >>> 15;
    endfunction

    function automatic void model_sample(input frame_t br, input frame_t bi, input int n,
                                         output int re, output int im);
        longint sr, si;
        sr = 0;
        si = 0;
        for (int k = 0; k < 8; k++) begin
            int a;
            a = (k * n) % 8;
            sr += qmul(br[k], cos_t[a]) - qmul(bi[k], sin_t[a]);
            si += qmul(br[k], sin_t[a]) + qmul(bi[k], cos_t[a]);
        end
        re = int'(sr >>> 3);
        im = int'(si >>> 3);
    endfunction

    function automatic void push_frame(input frame_t br, input frame_t bi);
        samp_t s;
        for (int n = 0; n < 8; n++) begin
            model_sample(br, bi, n, s.re, s.im);
            s.last = (n == 7);
            exp_q.push_back(s);
        end
    endfunction

    // ------------------------------------------------------------------
    // Cycle counter and out_ready driver
    // ------------------------------------------------------------------
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle out of reset
    // ------------------------------------------------------------------
    initial begin
        bit                  prev_stall;
        logic signed [W-1:0] prev_re, prev_im;
        logic                prev_last;
        samp_t               e;
        prev_stall = 1'b0;
        prev_re = '0;
        prev_im = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            chk_eq("in_ready_vs_busy", in_ready, !busy);
            if (!out_valid) chk_eq("last_without_valid", out_last, 0);
            if (prev_stall) begin
                chk_eq("stall_valid_held", out_valid, 1);
                chk_eq("stall_re_held", out_re, prev_re);
                chk_eq("stall_im_held", out_im, prev_im);
                chk_eq("stall_last_held", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1'b0, out_re, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("sample_re", out_re, e.re);
                    chk_eq("sample_im", out_im, e.im);
                    chk_eq("sample_last", out_last, e.last);
                end
                got_re[got_idx]   = out_re;
                got_im[got_idx]   = out_im;
                got_last[got_idx] = out_last;
                got_idx = (got_idx + 1) % 8;
                hs_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_re;
            prev_im    = out_im;
            prev_last  = out_last;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_bin(input int re, input int im);
        int tries;
        bit ok;
        tries = 0;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            tries++;
            if (tries > 300) begin
                chk("in_ready_timeout", 1'b0, 0, 1);
                break;
            end
        end
    endtask

    task automatic send_frame(input frame_t br, input frame_t bi, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && ($urandom_range(3) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_bin(br[k], bi[k]);
            if (k == 0) first_acc_cyc = cyc;
        end
        in_valid = 1'b0;
        push_frame(br, bi);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk_eq("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_dc_capture(string tag);
        for (int i = 0; i < 8; i++) begin
            chk_eq({tag, "_re"}, got_re[i], 100);
            chk_eq({tag, "_im"}, got_im[i], 0);
            chk_eq({tag, "_last"}, got_last[i], (i == 7));
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        frame_t dc_re, zero, imp_re, one_re, rr, ri;
        int     re, im, t0, t1, base, t;
        int     exp1_re [8] = '{1000, 707, 0, -708, -1000, -708, 0, 707};
        int     exp1_im [8] = '{0, 707, 1000, 707, 0, -708, -1000, -708};

        for (int k = 0; k < 8; k++) begin
            zero[k]   = 0;
            dc_re[k]  = (k == 0) ? 800 : 0;
            imp_re[k] = 8;
            one_re[k] = (k == 1) ? 8000 : 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_in_ready", in_ready, 1);
        chk_eq("rst_out_valid", out_valid, 0);
        chk_eq("rst_out_last", out_last, 0);
        chk_eq("rst_out_re", out_re, 0);
        chk_eq("rst_out_im", out_im, 0);
        chk_eq("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the model with hand-computed values
        for (int n = 0; n < 8; n++) begin
            model_sample(dc_re, zero, n, re, im);
            chk_eq("model_dc_re", re, 100);
            chk_eq("model_dc_im", im, 0);
            model_sample(one_re, zero, n, re, im);
            chk_eq("model_bin1_re", re, exp1_re[n]);
            chk_eq("model_bin1_im", im, exp1_im[n]);
            model_sample(imp_re, zero, n, re, im);
            // x0 = 64/8.  Even n uses only exact coefficients and sums to 0;
            // odd n floors 8*0.7071 to 5 twice and -8*0.7071 to -6 twice,
            // leaving -2 before the /8 floor, hence -1.
            chk_eq("model_imp_re", re, (n == 0) ? 8 : ((n % 2) ? -1 : 0));
            chk_eq("model_imp_im", im, (n == 0) ? 0 : ((n % 2) ? -1 : 0));
        end

        // DC frame
        or_mode = 1;
        got_idx = 0;
        send_frame(dc_re, zero, 1'b0);
        drain();
        check_dc_capture("dc");

        // Impulse spectrum and single bin
        send_frame(imp_re, zero, 1'b0);
        drain();
        chk_eq("imp_x0_re", got_re[0], 8);
        send_frame(one_re, zero, 1'b0);
        drain();
        chk_eq("bin1_x3_re", got_re[3], -708);
        chk_eq("bin1_x7_im", got_im[7], -708);

        // Backpressure with in_valid held high outside LOAD
        or_mode = 0;
        for (int k = 0; k < 8; k++) begin
            rr[k] = int'($urandom_range(4000)) - 2000;
            ri[k] = int'($urandom_range(4000)) - 2000;
        end
        send_frame(rr, ri, 1'b0);
        in_valid = 1'b1;
        in_re = 32'sd12345;
        in_im = -32'sd777;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        chk_eq("bp_valid_rose", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk_eq("bp_in_ready_low", in_ready, 0);
            chk_eq("bp_valid_held", out_valid, 1);
        end
        @(posedge clk);
        #1;
        or_mode = 1;
        // Keep in_valid high until the frame has been fully emitted so any
        // stray consumption would corrupt the following frames.
        t = 0;
        while (exp_q.size() > 1 && t < 500) begin
            @(posedge clk);
            t++;
        end
        in_valid = 1'b0;
        drain();

        // Reset in CALC for n=3, then a fresh DC frame
        send_frame(dc_re, zero, 1'b0);
        base = hs_count;
        t = 0;
        while (hs_count < base + 3 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk_eq("mid_rst_reached_n3", hs_count, base + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_out_valid", out_valid, 0);
        chk_eq("mid_rst_in_ready", in_ready, 1);
        repeat (20) @(posedge clk);   // no samples may appear from the old frame
        #1;
        got_idx = 0;
        send_frame(dc_re, zero, 1'b0);
        drain();
        check_dc_capture("post_rst_dc");

        // Throughput: two back-to-back frames with out_ready held high
        for (int k = 0; k < 8; k++) begin
            rr[k] = int'($urandom());
            ri[k] = int'($urandom());
        end
        send_frame(dc_re, zero, 1'b0);
        t0 = first_acc_cyc;
        send_frame(rr, ri, 1'b0);
        t1 = first_acc_cyc;
        chk_eq("frame_period", t1 - t0, 80);
        drain();

        // Random frames, random output backpressure and input gaps
        or_mode = 2;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f % 2 == 0) begin
                    rr[k] = int'($urandom());
                    ri[k] = int'($urandom());
                end else begin
                    rr[k] = int'($urandom_range(2000)) - 1000;
                    ri[k] = int'($urandom_range(2000)) - 1000;
                end
            end
            send_frame(rr, ri, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
